// File: rtl/idli_pkg.sv
// Shared idli types and helpers used by the decode front buffer and the decoder.
package idli_pkg;

    typedef logic [15:0] data_t;
    typedef logic [1:0]  ctr_t;

    typedef enum logic {
        DE_KIND_INSN = 1'b0,
        DE_KIND_IMM  = 1'b1
    } de_kind_t;

    typedef enum logic {
        S_INSN = 1'b0,
        S_IMM  = 1'b1
    } de_state_t;

    typedef struct packed {
        data_t    enc;
        de_kind_t kind;
        logic     imm_nxt;
    } de_entry_t;

    localparam int unsigned DE_DEPTH_DEFAULT = 2;

    // RHS is an SQI immediate unless the opcode class ignores the RHS field.
    function automatic logic de_needs_imm(input data_t enc);
        return (enc[3:0] == 4'hF) && !((enc[15:13] == 3'b100) || (enc[15:12] == 4'b1101));
    endfunction

endpackage

// File: rtl/idli_decode_buf_m_if.sv
// Fetch <-> decode buffer bundle: nibble stream and redirect in, queued head word out.
interface idli_decode_buf_m_if #(
    parameter int unsigned DEPTH = idli_pkg::DE_DEPTH_DEFAULT
);
    import idli_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    ctr_t             i_de_ctr;
    logic [3:0]       i_de_nib;
    logic             i_de_nib_vld;
    logic             i_de_flush;
    logic             i_de_pop;
    logic             o_de_vld;
    data_t            o_de_enc;
    de_kind_t         o_de_kind;
    logic             o_de_imm_nxt;
    logic             o_de_full;
    logic [CNT_W-1:0] o_de_cnt;
    logic             o_de_ovf;

    modport master (
        output i_de_ctr, i_de_nib, i_de_nib_vld, i_de_flush, i_de_pop,
        input  o_de_vld, o_de_enc, o_de_kind, o_de_imm_nxt, o_de_full, o_de_cnt, o_de_ovf
    );

    modport slave (
        input  i_de_ctr, i_de_nib, i_de_nib_vld, i_de_flush, i_de_pop,
        output o_de_vld, o_de_enc, o_de_kind, o_de_imm_nxt, o_de_full, o_de_cnt, o_de_ovf
    );

endinterface

// File: rtl/idli_decode_fifo_m.sv
// DEPTH-entry synchronous FIFO of decoded-word entries with flush and occupancy count.
module idli_decode_fifo_m
    import idli_pkg::*;
#(
    parameter int unsigned DEPTH = DE_DEPTH_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  de_entry_t                    wdata_i,
    output de_entry_t                    rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   cnt_o,
    output logic                         empty_o,
    output logic                         full_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    de_entry_t        mem_q [DEPTH];
    de_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign cnt_o   = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees the slot the push lands in, so full+pop+push is legal.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/idli_decode_buf_m.sv
// Decode front buffer: assembles SQI nibbles into 16b words, tags INSN/IMM, queues them.
// Optional same-cycle bypass of an empty FIFO when IDLI_DE_BYPASS_EN is defined.
module idli_decode_buf_m
    import idli_pkg::*;
#(
    parameter int unsigned DEPTH = DE_DEPTH_DEFAULT
) (
    input  logic                i_de_gck,
    input  logic                i_de_rst_n,
    idli_decode_buf_m_if.slave  de
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [2:0][3:0]  slot_q, slot_d;
    de_state_t        state_q, state_d;
    logic             ovf_q, ovf_d;

    data_t            word;
    logic             word_done;
    de_entry_t        new_entry;
    de_entry_t        fifo_rdata;
    de_entry_t        head;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty, fifo_full;
    logic             fifo_push, fifo_pop;
    logic             byp, byp_take;
    logic             head_vld, pop_eff;
    logic             accepted, drop;

    assign word_done = de.i_de_nib_vld && (de.i_de_ctr == 2'd3);
    assign word      = {slot_q[0], slot_q[1], slot_q[2], de.i_de_nib};

    always_comb begin
        new_entry.enc     = word;
        new_entry.kind    = (state_q == S_IMM) ? DE_KIND_IMM : DE_KIND_INSN;
        new_entry.imm_nxt = (state_q == S_INSN) && de_needs_imm(word);
    end

`ifdef IDLI_DE_BYPASS_EN
    assign byp = fifo_empty && word_done && !de.i_de_flush;
`else
    assign byp = 1'b0;
`endif

    assign head_vld  = !fifo_empty || byp;
    assign head      = fifo_empty ? new_entry : fifo_rdata;
    assign pop_eff   = de.i_de_pop && head_vld;
    assign byp_take  = byp && pop_eff;
    assign fifo_pop  = pop_eff && !fifo_empty;
    assign fifo_push = word_done && !byp_take;
    assign accepted  = word_done && !de.i_de_flush && (byp_take || !fifo_full || fifo_pop);
    assign drop      = word_done && !de.i_de_flush && fifo_full && !fifo_pop;

    always_comb begin
        slot_d  = slot_q;
        state_d = state_q;
        ovf_d   = drop;
        if (de.i_de_flush) begin
            slot_d  = '0;
            state_d = S_INSN;
        end else begin
            if (de.i_de_nib_vld) begin
                case (de.i_de_ctr)
                    2'd0:    slot_d[0] = de.i_de_nib;
                    2'd1:    slot_d[1] = de.i_de_nib;
                    2'd2:    slot_d[2] = de.i_de_nib;
                    default: ;
                endcase
            end
            if (accepted) begin
                state_d = new_entry.imm_nxt ? S_IMM : S_INSN;
            end
        end
    end

    always_ff @(posedge i_de_gck or negedge i_de_rst_n) begin
        if (!i_de_rst_n) begin
            slot_q  <= '0;
            state_q <= S_INSN;
            ovf_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    idli_decode_fifo_m #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (i_de_gck),
        .rst_ni  (i_de_rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (de.i_de_flush),
        .wdata_i (new_entry),
        .rdata_o (fifo_rdata),
        .cnt_o   (fifo_cnt),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Head fields read as zero/INSN whenever nothing is presented.
    always_comb begin
        de.o_de_vld     = head_vld;
        de.o_de_enc     = head_vld ? head.enc : '0;
        de.o_de_kind    = head_vld ? head.kind : DE_KIND_INSN;
        de.o_de_imm_nxt = head_vld && head.imm_nxt;
        de.o_de_full    = fifo_full;
        de.o_de_cnt     = fifo_cnt;
        de.o_de_ovf     = ovf_q;
    end

endmodule

// File: tb/tb_idli_decode_buf_m.sv
// Directed bench for idli_decode_buf_m (default build, DEPTH=2).
module tb_idli_decode_buf_m;
    import idli_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    idli_decode_buf_m_if #(.DEPTH(2)) de_if ();

    idli_decode_buf_m #(
        .DEPTH (2)
    ) dut (
        .i_de_gck   (clk),
        .i_de_rst_n (rst_n),
        .de         (de_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nib(input logic [1:0] c, input logic [3:0] n, input logic pop);
        de_if.i_de_ctr     = c;
        de_if.i_de_nib     = n;
        de_if.i_de_nib_vld = 1'b1;
        de_if.i_de_pop     = pop;
        tick();
        de_if.i_de_nib_vld = 1'b0;
        de_if.i_de_pop     = 1'b0;
    endtask

    task automatic word(input logic [15:0] w, input logic pop_last);
        nib(2'd0, w[15:12], 1'b0);
        nib(2'd1, w[11:8], 1'b0);
        nib(2'd2, w[7:4], 1'b0);
        nib(2'd3, w[3:0], pop_last);
    endtask

    task automatic pop1();
        de_if.i_de_pop = 1'b1;
        tick();
        de_if.i_de_pop = 1'b0;
    endtask

    task automatic head(input string tag, input logic [15:0] enc, input logic kind,
                        input logic imm, input logic [1:0] cnt);
        chk({tag, "_vld"}, 32'(de_if.o_de_vld), 32'(1'b1));
        chk({tag, "_enc"}, 32'(de_if.o_de_enc), 32'(enc));
        chk({tag, "_kind"}, 32'(de_if.o_de_kind), 32'(kind));
        chk({tag, "_imm"}, 32'(de_if.o_de_imm_nxt), 32'(imm));
        chk({tag, "_cnt"}, 32'(de_if.o_de_cnt), 32'(cnt));
    endtask

    task automatic idle(input string tag);
        chk({tag, "_vld"}, 32'(de_if.o_de_vld), 32'(1'b0));
        chk({tag, "_enc"}, 32'(de_if.o_de_enc), 32'h0);
        chk({tag, "_kind"}, 32'(de_if.o_de_kind), 32'(DE_KIND_INSN));
        chk({tag, "_imm"}, 32'(de_if.o_de_imm_nxt), 32'h0);
        chk({tag, "_full"}, 32'(de_if.o_de_full), 32'h0);
        chk({tag, "_cnt"}, 32'(de_if.o_de_cnt), 32'h0);
        chk({tag, "_ovf"}, 32'(de_if.o_de_ovf), 32'h0);
    endtask

    initial begin
        checks             = 0;
        failures           = 0;
        rst_n              = 1'b0;
        de_if.i_de_ctr     = 2'd0;
        de_if.i_de_nib     = 4'h0;
        de_if.i_de_nib_vld = 1'b0;
        de_if.i_de_flush   = 1'b0;
        de_if.i_de_pop     = 1'b0;
        tick();
        idle("reset");
        rst_n = 1'b1;
        tick();

        // Basic assembly, latency 1.
        word(16'h1234, 1'b0);
        head("w1234", 16'h1234, DE_KIND_INSN, 1'b0, 2'd1);
        pop1();
        idle("pop_empty");

        // INSN needing an immediate, then IMM, then an excluded class.
        word(16'h012F, 1'b0);
        head("w012f", 16'h012F, DE_KIND_INSN, 1'b1, 2'd1);
        word(16'hBEEF, 1'b0);
        chk("full_after_two", 32'(de_if.o_de_full), 32'h1);
        pop1();
        head("wbeef_imm", 16'hBEEF, DE_KIND_IMM, 1'b0, 2'd1);
        pop1();
        word(16'h8ABF, 1'b0);
        head("w8abf", 16'h8ABF, DE_KIND_INSN, 1'b0, 2'd1);
        pop1();

        // Overflow on third push with no pop.
        word(16'h1111, 1'b0);
        word(16'h2222, 1'b0);
        chk("full2_full", 32'(de_if.o_de_full), 32'h1);
        word(16'h3333, 1'b0);
        chk("ovf_pulse", 32'(de_if.o_de_ovf), 32'h1);
        head("ovf_head", 16'h1111, DE_KIND_INSN, 1'b0, 2'd2);
        tick();
        chk("ovf_clears", 32'(de_if.o_de_ovf), 32'h0);

        // Full FIFO, pop and push in the same cycle.
        word(16'h4444, 1'b1);
        chk("pp_ovf", 32'(de_if.o_de_ovf), 32'h0);
        head("pp_head", 16'h2222, DE_KIND_INSN, 1'b0, 2'd2);
        pop1();
        head("pp_tail", 16'h4444, DE_KIND_INSN, 1'b0, 2'd1);
        pop1();
        chk("pp_empty", 32'(de_if.o_de_vld), 32'h0);

        // Flush resets class state; BEEF becomes an INSN needing an immediate.
        word(16'h012F, 1'b0);
        de_if.i_de_flush = 1'b1;
        tick();
        de_if.i_de_flush = 1'b0;
        idle("flush");
        word(16'hBEEF, 1'b0);
        head("flush_beef", 16'hBEEF, DE_KIND_INSN, 1'b1, 2'd1);
        de_if.i_de_flush = 1'b1;
        tick();
        de_if.i_de_flush = 1'b0;

        // Async reset mid-word clears queue and assembly slots.
        word(16'h5555, 1'b0);
        nib(2'd0, 4'hA, 1'b0);
        nib(2'd1, 4'hB, 1'b0);
        rst_n = 1'b0;
        #1;
        idle("async_rst");
        rst_n = 1'b1;
        nib(2'd2, 4'hC, 1'b0);
        nib(2'd3, 4'hD, 1'b0);
        head("zero_fill", 16'h00CD, DE_KIND_INSN, 1'b0, 2'd1);
        pop1();
        word(16'h6789, 1'b0);
        head("post_rst", 16'h6789, DE_KIND_INSN, 1'b0, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
